// File: rtl/tx_ft245.sv
// ---------------------------------------------------------------------------
// tx_ft245 -- tx byte FIFO plus FT245-style parallel USB FIFO write sequencer.
//
// The upstream mux writes bytes through winc/wfull.  Bytes are drained to the
// FT245 bus one at a time using a timed WR# strobe:
//    SETUP  : data driven, WR# high  (SETUP_CYC cycles)
//    STROBE : WR# low                (STROBE_CYC cycles)
//    HOLD   : data held, WR# high    (HOLD_CYC cycles)
// A byte is popped from the FIFO when the sequencer leaves IDLE, and a popped
// byte is always completed, even if TXE# rises during the transfer.
//
// Optional feature, macro TX_FT_SIWU_EN: after a byte has been sent and the
// FIFO then stays empty for SIWU_IDLE idle cycles, SIWU# is pulsed low for
// STROBE_CYC cycles to flush the device buffer to the host.  Without the
// macro, ft_siwu_n is tied high and no idle counter is built.
//
// Ports:
//    clk        in   system clock
//    rst        in   synchronous reset, active-high
//    wdata      in   byte from mux
//    winc       in   write strobe, one byte per cycle
//    wfull      out  FIFO full (registered)
//    wcount     out  FIFO occupancy (registered), ADDR_W+1 bits
//    ft_txe_n   in   FT245 TXE#, asynchronous, low = device accepts a byte
//    ft_data    out  byte to FT245 bus
//    ft_data_oe out  output enable for ft_data
//    ft_wr_n    out  FT245 WR#
//    ft_siwu_n  out  FT245 SIWU#
// ---------------------------------------------------------------------------
module tx_ft245 #(
   parameter int ADDR_W     = 4,
   parameter int SETUP_CYC  = 2,
   parameter int STROBE_CYC = 3,
   parameter int HOLD_CYC   = 1,
   parameter int SIWU_IDLE  = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        wdata,
   input  logic              winc,
   output logic              wfull,
   output logic [ADDR_W:0]   wcount,
   input  logic              ft_txe_n,
   output logic [7:0]        ft_data,
   output logic              ft_data_oe,
   output logic              ft_wr_n,
   output logic              ft_siwu_n
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int MAXC  = (SETUP_CYC > STROBE_CYC) ?
                          ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                          ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
   localparam int CW    = (MAXC > 1) ? $clog2(MAXC) : 1;

   localparam logic [ADDR_W:0] DEPTH_C    = (ADDR_W+1)'(DEPTH);
   localparam logic [CW-1:0]   SETUP_LD   = CW'(SETUP_CYC - 1);
   localparam logic [CW-1:0]   STROBE_LD  = CW'(STROBE_CYC - 1);
   localparam logic [CW-1:0]   HOLD_LD    = CW'(HOLD_CYC - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      HOLD   = 2'd3
   } state_t;

   logic [7:0]      mem [DEPTH];
   logic [ADDR_W:0] wptr_r;
   logic [ADDR_W:0] rptr_r;
   logic [ADDR_W:0] count_r;
   logic [ADDR_W:0] count_nxt_s;
   logic            full_r;
   logic            txe_meta_r;
   logic            txe_sync_r;      // synchronised TXE#
   state_t          state_r;
   state_t          state_nxt_s;
   logic [CW-1:0]   cnt_r;
   logic [CW-1:0]   cnt_nxt_s;
   logic [7:0]      data_r;
   logic            oe_r;
   logic            wr_n_r;
   logic            accept_s;
   logic            pop_s;
   logic            siwu_hold_s;

   // wfull is a register, so acceptance never depends combinationally on winc
   assign accept_s = winc && !full_r;
   assign pop_s    = (state_r == IDLE) && (count_r != {(ADDR_W+1){1'b0}}) &&
                     !txe_sync_r && !siwu_hold_s;

   assign wfull      = full_r;
   assign wcount     = count_r;
   assign ft_data    = data_r;
   assign ft_data_oe = oe_r;
   assign ft_wr_n    = wr_n_r;

   // Next occupancy: a simultaneous accept and pop leaves it unchanged
   always_comb begin
      count_nxt_s = count_r;
      if (accept_s && !pop_s) begin
         count_nxt_s = count_r + {{ADDR_W{1'b0}}, 1'b1};
      end else if (pop_s && !accept_s) begin
         count_nxt_s = count_r - {{ADDR_W{1'b0}}, 1'b1};
      end else begin
         count_nxt_s = count_r;
      end
   end

   // FIFO storage; contents are don't-care after reset, so no reset here
   always_ff @(posedge clk) begin
      if (accept_s) begin
         mem[wptr_r[ADDR_W-1:0]] <= wdata;
      end
   end

   // FIFO pointers, occupancy and full flag
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_r  <= {(ADDR_W+1){1'b0}};
         rptr_r  <= {(ADDR_W+1){1'b0}};
         count_r <= {(ADDR_W+1){1'b0}};
         full_r  <= 1'b0;
      end else begin
         if (accept_s) begin
            wptr_r <= wptr_r + {{ADDR_W{1'b0}}, 1'b1};
         end
         if (pop_s) begin
            rptr_r <= rptr_r + {{ADDR_W{1'b0}}, 1'b1};
         end
         count_r <= count_nxt_s;
         full_r  <= (count_nxt_s == DEPTH_C);
      end
   end

   // Two-flop synchroniser for TXE#; resets to "device not ready"
   always_ff @(posedge clk) begin
      if (rst) begin
         txe_meta_r <= 1'b1;
         txe_sync_r <= 1'b1;
      end else begin
         txe_meta_r <= ft_txe_n;
         txe_sync_r <= txe_meta_r;
      end
   end

   // Sequencer next state; the down-counter is loaded with N-1 on state entry
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         IDLE: begin
            if (pop_s) begin
               state_nxt_s = SETUP;
               cnt_nxt_s   = SETUP_LD;
            end else begin
               state_nxt_s = IDLE;
               cnt_nxt_s   = {CW{1'b0}};
            end
         end
         SETUP: begin
            if (cnt_r == {CW{1'b0}}) begin
               state_nxt_s = STROBE;
               cnt_nxt_s   = STROBE_LD;
            end else begin
               cnt_nxt_s   = cnt_r - {{(CW-1){1'b0}}, 1'b1};
            end
         end
         STROBE: begin
            if (cnt_r == {CW{1'b0}}) begin
               state_nxt_s = HOLD;
               cnt_nxt_s   = HOLD_LD;
            end else begin
               cnt_nxt_s   = cnt_r - {{(CW-1){1'b0}}, 1'b1};
            end
         end
         HOLD: begin
            if (cnt_r == {CW{1'b0}}) begin
               state_nxt_s = IDLE;
               cnt_nxt_s   = {CW{1'b0}};
            end else begin
               cnt_nxt_s   = cnt_r - {{(CW-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = {CW{1'b0}};
         end
      endcase
   end

   // Sequencer state plus bus outputs registered from the next state so
   // WR#/OE line up exactly with the state they belong to
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         cnt_r   <= {CW{1'b0}};
         data_r  <= 8'h00;
         oe_r    <= 1'b0;
         wr_n_r  <= 1'b1;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         if (pop_s) begin
            data_r <= mem[rptr_r[ADDR_W-1:0]];
         end
         oe_r    <= (state_nxt_s != IDLE);
         wr_n_r  <= (state_nxt_s != STROBE);
      end
   end

`ifdef TX_FT_SIWU_EN
   localparam int            IW        = $clog2(SIWU_IDLE + 1);
   localparam logic [IW-1:0] SIWU_LAST = IW'(SIWU_IDLE - 1);

   logic          sent_r;
   logic [IW-1:0] idle_cnt_r;
   logic          siwu_act_r;
   logic [CW-1:0] siwu_cnt_r;
   logic          siwu_n_r;

   // While SIWU# is low the sequencer is held in IDLE
   assign siwu_hold_s = siwu_act_r;
   assign ft_siwu_n   = siwu_n_r;

   // Idle counting after a sent byte and the SIWU# pulse itself
   always_ff @(posedge clk) begin
      if (rst) begin
         sent_r     <= 1'b0;
         idle_cnt_r <= {IW{1'b0}};
         siwu_act_r <= 1'b0;
         siwu_cnt_r <= {CW{1'b0}};
         siwu_n_r   <= 1'b1;
      end else if (siwu_act_r) begin
         // a write during the pulse does not shorten it
         if (siwu_cnt_r == {CW{1'b0}}) begin
            siwu_act_r <= 1'b0;
            siwu_n_r   <= 1'b1;
            sent_r     <= 1'b0;
            idle_cnt_r <= {IW{1'b0}};
         end else begin
            siwu_cnt_r <= siwu_cnt_r - {{(CW-1){1'b0}}, 1'b1};
         end
      end else begin
         if (pop_s) begin
            sent_r <= 1'b1;
         end
         if (accept_s || (state_r != IDLE) || pop_s) begin
            idle_cnt_r <= {IW{1'b0}};
         end else if (sent_r && (count_r == {(ADDR_W+1){1'b0}})) begin
            idle_cnt_r <= idle_cnt_r + {{(IW-1){1'b0}}, 1'b1};
            if (idle_cnt_r == SIWU_LAST) begin
               siwu_act_r <= 1'b1;
               siwu_n_r   <= 1'b0;
               siwu_cnt_r <= STROBE_LD;
            end
         end
      end
   end
`else
   assign siwu_hold_s = 1'b0;
   assign ft_siwu_n   = 1'b1;
`endif

endmodule

// File: tb/tb_tx_ft245.sv
// ---------------------------------------------------------------------------
// tb_tx_ft245 -- scoreboard bench for tx_ft245.
// Stimulus pushes every byte it expects to be sent onto exp_q; an independent
// monitor pops and compares on every falling WR# edge.  Cycle-exact latency
// and SIWU# timing use hand-computed tables.
// ---------------------------------------------------------------------------
module tb_tx_ft245;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] wdata = 8'h00;
   logic       winc = 1'b0;
   logic       wfull;
   logic [4:0] wcount;
   logic       ft_txe_n = 1'b1;
   logic [7:0] ft_data;
   logic       ft_data_oe;
   logic       ft_wr_n;
   logic       ft_siwu_n;

   int         total = 0;
   int         bad = 0;
   int         strobes = 0;
   logic [7:0] exp_q[$];
   logic       running = 1'b0;

   tx_ft245 #(.ADDR_W(4), .SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(1), .SIWU_IDLE(10)) dut (
      .clk(clk), .rst(rst), .wdata(wdata), .winc(winc), .wfull(wfull), .wcount(wcount),
      .ft_txe_n(ft_txe_n), .ft_data(ft_data), .ft_data_oe(ft_data_oe),
      .ft_wr_n(ft_wr_n), .ft_siwu_n(ft_siwu_n)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // bench copy of the TXE synchroniser, used for the pop-time rule
   logic s1 = 1'b1, s2 = 1'b1;
   always @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
      end else begin
         s1 <= ft_txe_n;
         s2 <= s1;
      end
   end

   // monitor: compare each strobed byte against the scoreboard
   initial begin
      logic       prev_wr;
      logic       prev_oe;
      logic       prev_s2;
      logic [7:0] e;
      prev_wr = 1'b1;
      prev_oe = 1'b0;
      prev_s2 = 1'b1;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_wr = 1'b1;
            prev_oe = 1'b0;
            prev_s2 = 1'b1;
         end else begin
            if (prev_wr && !ft_wr_n) begin
               strobes++;
               if (exp_q.size() == 0) begin
                  check("unexpected_strobe", {24'h0, ft_data}, 32'h1ff);
               end else begin
                  e = exp_q.pop_front();
                  check("strobe_data", {24'h0, ft_data}, {24'h0, e});
                  check("strobe_oe", {31'h0, ft_data_oe}, 32'h1);
               end
            end
            if (!prev_oe && ft_data_oe) begin
               check("txe_at_pop", {31'h0, prev_s2}, 32'h0);
            end
            prev_wr = ft_wr_n;
            prev_oe = ft_data_oe;
            prev_s2 = s2;
         end
      end
   end

   task automatic reset_dut(input logic txe);
      @(negedge clk);
      rst = 1'b1;
      winc = 1'b0;
      ft_txe_n = txe;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      repeat (3) @(negedge clk);
   endtask

   task automatic push_byte(input logic [7:0] d);
      winc = 1'b1;
      wdata = d;
      exp_q.push_back(d);
   endtask

   task automatic fill(input logic [7:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         push_byte(base + 8'(i));
         @(negedge clk);
      end
      winc = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || ft_data_oe || wcount != 5'd0) && n < 600) begin
         @(negedge clk);
         n++;
      end
      check(name, exp_q.size(), 0);
      check({name, "_idle"}, {31'h0, ft_data_oe}, 32'h0);
   endtask

   // cycle-exact latency table for one byte written in cycle 0
   logic [4:0] t_cnt[1:8] = '{5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
   logic       t_oe [1:8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
   logic       t_wr [1:8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

   initial begin
      int s0;
      int idx;
      int guard;
      logic [7:0] d;
      logic exp_siwu;

      // ---- reset values (rst held high)
      ft_txe_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_wcount", {27'h0, wcount}, 32'h0);
      check("rst_wfull", {31'h0, wfull}, 32'h0);
      check("rst_wr_n", {31'h0, ft_wr_n}, 32'h1);
      check("rst_oe", {31'h0, ft_data_oe}, 32'h0);
      check("rst_data", {24'h0, ft_data}, 32'h0);
      check("rst_siwu", {31'h0, ft_siwu_n}, 32'h1);

      // ---- T1: single byte latency
      reset_dut(1'b0);
      push_byte(8'hA5);
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         winc = 1'b0;
         check($sformatf("lat_wcount_c%0d", c), {27'h0, wcount}, {27'h0, t_cnt[c]});
         check($sformatf("lat_oe_c%0d", c), {31'h0, ft_data_oe}, {31'h0, t_oe[c]});
         check($sformatf("lat_wr_c%0d", c), {31'h0, ft_wr_n}, {31'h0, t_wr[c]});
         if (c >= 2 && c <= 7) check($sformatf("lat_data_c%0d", c), {24'h0, ft_data}, 32'hA5);
      end
      wait_drain("t1_drain");

      // ---- T2: fill to full, overflow dropped, ordered drain
      reset_dut(1'b1);
      for (int i = 0; i < 16; i++) begin
         push_byte(8'(i));
         @(negedge clk);
      end
      check("full_wcount", {27'h0, wcount}, 32'd16);
      check("full_wfull", {31'h0, wfull}, 32'h1);
      wdata = 8'hFF;               // 17th write, not pushed: must be dropped
      @(negedge clk);
      winc = 1'b0;
      check("ovf_wcount", {27'h0, wcount}, 32'd16);
      check("ovf_wfull", {31'h0, wfull}, 32'h1);
      s0 = strobes;
      ft_txe_n = 1'b0;
      wait_drain("t2_drain");
      repeat (20) @(negedge clk);
      check("t2_strobes", strobes - s0, 16);
      check("t2_wr_high", {31'h0, ft_wr_n}, 32'h1);

      // ---- T3: mux bursts at full rate with TXE# toggling
      reset_dut(1'b0);
      running = 1'b1;
      fork
         begin
            while (running) begin
               repeat (20) @(negedge clk);
               ft_txe_n = ~ft_txe_n;
            end
         end
         begin
            idx = 0;
            guard = 0;
            while (idx < 30 && guard < 3000) begin
               if (!wfull) begin
                  case (idx % 3)
                     0:       d = 8'hC0 | 8'(idx / 3);
                     1:       d = 8'(idx * 7);
                     default: d = ~8'(idx);
                  endcase
                  push_byte(d);
                  idx++;
               end else begin
                  winc = 1'b0;
               end
               @(negedge clk);
               guard++;
            end
            winc = 1'b0;
            check("t3_sent_all", idx, 30);
            running = 1'b0;
         end
      join
      ft_txe_n = 1'b0;
      wait_drain("t3_drain");

      // ---- T4a: 15 entries, write concurrent with pop
      reset_dut(1'b1);
      fill(8'h10, 15);
      ft_txe_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      push_byte(8'h1F);
      @(negedge clk);
      winc = 1'b0;
      check("c15_wcount", {27'h0, wcount}, 32'd15);
      check("c15_oe", {31'h0, ft_data_oe}, 32'h1);
      wait_drain("t4a_drain");

      // ---- T4b: 16 entries, write concurrent with pop is dropped
      reset_dut(1'b1);
      fill(8'h20, 16);
      ft_txe_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      winc = 1'b1;
      wdata = 8'hEE;
      @(negedge clk);
      winc = 1'b0;
      check("c16_wcount", {27'h0, wcount}, 32'd15);
      check("c16_wfull", {31'h0, wfull}, 32'h0);
      wait_drain("t4b_drain");

      // ---- T5: reset during STROBE
      reset_dut(1'b0);
      push_byte(8'h77);
      @(negedge clk);
      push_byte(8'h78);
      @(negedge clk);
      winc = 1'b0;
      guard = 0;
      while (ft_wr_n && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check("t5_saw_strobe", {31'h0, ft_wr_n}, 32'h0);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_wr_n", {31'h0, ft_wr_n}, 32'h1);
      check("mid_rst_oe", {31'h0, ft_data_oe}, 32'h0);
      check("mid_rst_wcount", {27'h0, wcount}, 32'h0);
      check("mid_rst_wfull", {31'h0, wfull}, 32'h0);
      exp_q.delete();
      s0 = strobes;
      rst = 1'b0;
      repeat (30) @(negedge clk);
      check("t5_no_strobes", strobes - s0, 0);
      check("t5_wr_high", {31'h0, ft_wr_n}, 32'h1);

      // ---- T6: SIWU# after idle (tied high when the feature is off)
      reset_dut(1'b0);
      push_byte(8'h5A);
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         winc = 1'b0;
`ifdef TX_FT_SIWU_EN
         exp_siwu = !(c >= 18 && c <= 20);
`else
         exp_siwu = 1'b1;
`endif
         check($sformatf("siwu_a_c%0d", c), {31'h0, ft_siwu_n}, {31'h0, exp_siwu});
      end
      reset_dut(1'b0);
      push_byte(8'h6B);
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         winc = 1'b0;
         if (c == 12) push_byte(8'h3C);   // 5th idle cycle
`ifdef TX_FT_SIWU_EN
         exp_siwu = !(c >= 30 && c <= 32);
`else
         exp_siwu = 1'b1;
`endif
         check($sformatf("siwu_b_c%0d", c), {31'h0, ft_siwu_n}, {31'h0, exp_siwu});
      end
      wait_drain("t6_drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
